// File: rtl/drop_scheduler.sv
// drop_scheduler: walks a note chart and launches lane droppers when each entry
// falls due. It also accumulates the score and the consecutive-hit combo.
// Optional feature: define COMBO_BONUS_EN so that each hit earns an extra
// (combo >> 3) points on top of SCORE_PER_HIT.
module drop_scheduler #(
    parameter int LANES         = 6,
    parameter int SCORE_PER_HIT = 10
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic [7:0]       keycode,
    output logic [4:0]       chart_addr,
    input  logic [11:0]      chart_time,
    input  logic [2:0]       chart_lane,
    input  logic             chart_last,
    input  logic [LANES-1:0] lane_busy,
    input  logic [LANES-1:0] hit,
    input  logic [LANES-1:0] miss,
    output logic [LANES-1:0] launch,
    output logic [15:0]      score,
    output logic [7:0]       combo,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [7:0] KEY_START  = 8'h2C;
    localparam logic [7:0] KEY_ABORT  = 8'h01;
    localparam logic [3:0] LANE_COUNT = 4'(LANES);

    state_t      state_q, state_d;
    logic [11:0] frame_cnt_q, frame_cnt_d;
    logic [4:0]  chart_addr_q, chart_addr_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  combo_q, combo_d;

    logic [LANES-1:0] good_hits;
    logic [3:0]       hit_cnt;
    logic [31:0]      per_hit;
    logic [31:0]      score_sum;
    logic [8:0]       combo_sum;
    logic             lane_valid;
    logic             lane_free;
    logic             entry_due;
    logic             entry_done;
    logic             honour;

    // Count this frame's clean hits and form the unsaturated score and combo sums
    always_comb begin
        good_hits = hit & ~miss;
        hit_cnt   = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            hit_cnt = hit_cnt + 4'(good_hits[i]);
        end
`ifdef COMBO_BONUS_EN
        per_hit = 32'(SCORE_PER_HIT) + {27'd0, combo_q[7:3]};
`else
        per_hit = 32'(SCORE_PER_HIT);
`endif
        score_sum = {16'd0, score_q} + ({28'd0, hit_cnt} * per_hit);
        combo_sum = {1'b0, combo_q} + {5'd0, hit_cnt};
    end

    // Next-state logic, chart walking, launch pulse and score/combo update
    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        chart_addr_d = chart_addr_q;
        score_d      = score_q;
        combo_d      = combo_q;
        launch       = '0;
        entry_due    = (frame_cnt_q >= chart_time);
        lane_valid   = ({1'b0, chart_lane} < LANE_COUNT);
        lane_free    = 1'b0;
        entry_done   = 1'b0;
        honour       = (state_q == ST_PLAY) || (state_q == ST_DRAIN);

        for (int i = 0; i < LANES; i++) begin
            if (chart_lane == 3'(i)) begin
                lane_free = ~lane_busy[i];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (keycode == KEY_START) begin
                    state_d      = ST_PLAY;
                    frame_cnt_d  = 12'd0;
                    chart_addr_d = 5'd0;
                    score_d      = 16'd0;
                    combo_d      = 8'd0;
                end
            end
            ST_PLAY: begin
                if (frame_cnt_q != 12'hFFF) begin
                    frame_cnt_d = frame_cnt_q + 12'd1;
                end
                if (keycode == KEY_ABORT) begin
                    state_d = ST_DONE;
                end else if (entry_due) begin
                    if (!lane_valid) begin
                        entry_done = 1'b1;
                    end else if (lane_free) begin
                        entry_done = 1'b1;
                        for (int i = 0; i < LANES; i++) begin
                            if (chart_lane == 3'(i)) begin
                                launch[i] = 1'b1;
                            end
                        end
                    end
                end
                if (entry_done) begin
                    if (chart_addr_q != 5'd31) begin
                        chart_addr_d = chart_addr_q + 5'd1;
                    end
                    if (chart_last || (chart_addr_q == 5'd31)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((keycode == KEY_ABORT) || (lane_busy == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (keycode == KEY_ABORT) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (honour) begin
            score_d = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];
            if (miss != '0) begin
                combo_d = 8'd0;
            end else begin
                combo_d = combo_sum[8] ? 8'hFF : combo_sum[7:0];
            end
        end
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= 12'd0;
            chart_addr_q <= 5'd0;
            score_q      <= 16'd0;
            combo_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            chart_addr_q <= chart_addr_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
        end
    end

    assign chart_addr = chart_addr_q;
    assign score      = score_q;
    assign combo      = combo_q;
    assign state      = state_q;

endmodule

// File: tb/tb_drop_scheduler.sv
// tb_drop_scheduler: directed and randomized checks of drop_scheduler against
// a behavioural game model kept in the bench.
module tb_drop_scheduler;

   localparam int LANES         = 6;
   localparam int SCORE_PER_HIT = 10;
   localparam int S_IDLE  = 0;
   localparam int S_PLAY  = 1;
   localparam int S_DRAIN = 2;
   localparam int S_DONE  = 3;

   logic             frame_clk = 1'b0;
   logic             Reset;
   logic [7:0]       keycode;
   logic [4:0]       chart_addr;
   logic [11:0]      chart_time;
   logic [2:0]       chart_lane;
   logic             chart_last;
   logic [LANES-1:0] lane_busy;
   logic [LANES-1:0] hit;
   logic [LANES-1:0] miss;
   logic [LANES-1:0] launch;
   logic [15:0]      score;
   logic [7:0]       combo;
   logic [1:0]       state;

   // The chart ROM lives in the bench and answers the DUT's address combinationally
   logic [11:0] romTime [32];
   logic [2:0]  romLane [32];
   logic        romLast [32];

   assign chart_time = romTime[chart_addr];
   assign chart_lane = romLane[chart_addr];
   assign chart_last = romLast[chart_addr];

   drop_scheduler #(
      .LANES(LANES),
      .SCORE_PER_HIT(SCORE_PER_HIT)
   ) dut (
      .frame_clk(frame_clk),
      .Reset(Reset),
      .keycode(keycode),
      .chart_addr(chart_addr),
      .chart_time(chart_time),
      .chart_lane(chart_lane),
      .chart_last(chart_last),
      .lane_busy(lane_busy),
      .hit(hit),
      .miss(miss),
      .launch(launch),
      .score(score),
      .combo(combo),
      .state(state)
   );

   // Free-running frame clock, one period per video frame
   always #5 frame_clk = ~frame_clk;

   int checkCount = 0;
   int errorCount = 0;

   // Reference game model: current values and the values after the next frame edge
   int               modelState, modelFrame, modelScore, modelCombo;
   logic [4:0]       modelAddr;
   int               nextState, nextFrame, nextScore, nextCombo;
   logic [4:0]       nextAddr;
   logic [LANES-1:0] expLaunch;

   // Record of launch pulses seen on the DUT, used by the directed scenarios
   int               launchCount;
   int               launchFrame;
   logic [LANES-1:0] launchBits;

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Play the game rules for one frame from the model's present values and inputs
   task automatic modelEval();
      int  lane;
      int  clean;
      int  perHit;
      bit  consumed;
      nextState = modelState;
      nextFrame = modelFrame;
      nextAddr  = modelAddr;
      nextScore = modelScore;
      nextCombo = modelCombo;
      expLaunch = '0;
      consumed  = 1'b0;
      if (modelState == S_IDLE) begin
         if (keycode == 8'h2C) begin
            nextState = S_PLAY;
            nextFrame = 0;
            nextAddr  = 5'd0;
            nextScore = 0;
            nextCombo = 0;
         end
      end else if (modelState == S_PLAY) begin
         nextFrame = (modelFrame < 4095) ? modelFrame + 1 : 4095;
         if (keycode == 8'h01) begin
            nextState = S_DONE;
         end else if (modelFrame >= int'(romTime[modelAddr])) begin
            lane = int'(romLane[modelAddr]);
            if (lane >= LANES) begin
               consumed = 1'b1;
            end else if (!lane_busy[lane[2:0]]) begin
               expLaunch[lane[2:0]] = 1'b1;
               consumed = 1'b1;
            end
         end
         if (consumed) begin
            if (romLast[modelAddr] || modelAddr == 5'd31) nextState = S_DRAIN;
            if (modelAddr != 5'd31) nextAddr = modelAddr + 5'd1;
         end
      end else if (modelState == S_DRAIN) begin
         if (keycode == 8'h01 || lane_busy == '0) nextState = S_DONE;
      end else begin
         if (keycode == 8'h01) nextState = S_IDLE;
      end
      if (modelState == S_PLAY || modelState == S_DRAIN) begin
         clean  = $countones(hit & ~miss);
         perHit = SCORE_PER_HIT;
`ifdef COMBO_BONUS_EN
         perHit = perHit + modelCombo / 8;
`endif
         nextScore = modelScore + clean * perHit;
         if (nextScore > 65535) nextScore = 65535;
         if (miss != '0) nextCombo = 0;
         else nextCombo = (modelCombo + clean > 255) ? 255 : modelCombo + clean;
      end
   endtask

   // Drive one frame of inputs, compare everything mid-frame, then advance the model
   task automatic applyStimulus(input logic [7:0] key, input logic [LANES-1:0] busy,
                                input logic [LANES-1:0] hits, input logic [LANES-1:0] misses);
      keycode   = key;
      lane_busy = busy;
      hit       = hits;
      miss      = misses;
      modelEval();
      @(negedge frame_clk);
      checkOutput("state", 32'(state), 32'(modelState));
      checkOutput("chart_addr", 32'(chart_addr), 32'(modelAddr));
      checkOutput("score", 32'(score), 32'(modelScore));
      checkOutput("combo", 32'(combo), 32'(modelCombo));
      checkOutput("launch", 32'(launch), 32'(expLaunch));
      if (launch != '0) begin
         launchCount++;
         launchFrame = modelFrame;
         launchBits  = launch;
      end
      @(posedge frame_clk);
      modelState = nextState;
      modelFrame = nextFrame;
      modelAddr  = nextAddr;
      modelScore = nextScore;
      modelCombo = nextCombo;
      #1;
   endtask

   // Put the model at its reset values
   task automatic modelReset();
      modelState = S_IDLE;
      modelFrame = 0;
      modelAddr  = 5'd0;
      modelScore = 0;
      modelCombo = 0;
   endtask

   // Assert reset asynchronously, check the cleared outputs, release after an edge
   task automatic resetDut();
      keycode   = 8'h00;
      lane_busy = '0;
      hit       = '0;
      miss      = '0;
      Reset     = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_state", 32'(state), 32'(S_IDLE));
      checkOutput("rst_addr", 32'(chart_addr), 32'd0);
      checkOutput("rst_score", 32'(score), 32'd0);
      checkOutput("rst_combo", 32'(combo), 32'd0);
      checkOutput("rst_launch", 32'(launch), 32'd0);
      @(posedge frame_clk);
      #1;
      Reset = 1'b1;
      launchCount = 0;
      launchFrame = -1;
      launchBits  = '0;
   endtask

   // Fill the chart with one never-due last entry everywhere
   task automatic clearChart();
      for (int i = 0; i < 32; i++) begin
         romTime[i] = 12'hFFF;
         romLane[i] = 3'd0;
         romLast[i] = 1'b1;
      end
   endtask

   // Random chart with nondecreasing times; optionally no last marker at all
   task automatic loadRandomChart(input bit withLast);
      int t;
      t = 0;
      for (int i = 0; i < 32; i++) begin
         t = t + int'($urandom_range(0, 6));
         romTime[i] = 12'(t);
         romLane[i] = 3'($urandom_range(0, 7));
         romLast[i] = withLast && ($urandom_range(0, 9) == 0);
      end
   endtask

   initial begin
      int guard;
      logic [7:0] key;
      int pick;

      $display("[TB] drop_scheduler bench starting");
      Reset     = 1'b0;
      keycode   = 8'h00;
      lane_busy = '0;
      hit       = '0;
      miss      = '0;
      clearChart();
      #2;
      resetDut();

      // One entry due at frame 5 on lane 2, then drain while the lane stays busy
      clearChart();
      romTime[0] = 12'd5;
      romLane[0] = 3'd2;
      romLast[0] = 1'b1;
      resetDut();
      applyStimulus(8'h2C, '0, '0, '0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(8'h00, (modelState == S_DRAIN && i < 9) ? 6'b000100 : 6'b000000, '0, '0);
      end
      checkOutput("t1_launch_count", 32'(launchCount), 32'd1);
      checkOutput("t1_launch_frame", 32'(launchFrame), 32'd5);
      checkOutput("t1_launch_bits", 32'(launchBits), 32'b000100);
      checkOutput("t1_done", 32'(state), 32'(S_DONE));
      applyStimulus(8'h01, '0, '0, '0);
      checkOutput("t1_return_idle", 32'(state), 32'(S_IDLE));

      // Lane 1 busy through frame 9 stalls an entry due at frame 3; lane 7 entry is skipped
      clearChart();
      romTime[0] = 12'd3;
      romLane[0] = 3'd1;
      romLast[0] = 1'b0;
      romTime[1] = 12'd15;
      romLane[1] = 3'd7;
      romLast[1] = 1'b1;
      resetDut();
      applyStimulus(8'h2C, '0, '0, '0);
      for (int i = 0; i < 20; i++) begin
         if (modelState == S_PLAY && modelFrame == 12) begin
            checkOutput("t2_addr_after_launch", 32'(chart_addr), 32'd1);
         end
         applyStimulus(8'h00, (modelState == S_PLAY && modelFrame <= 9) ? 6'b000010 : 6'b000000, '0, '0);
      end
      checkOutput("t2_launch_count", 32'(launchCount), 32'd1);
      checkOutput("t2_launch_frame", 32'(launchFrame), 32'd10);
      checkOutput("t2_launch_bits", 32'(launchBits), 32'b000010);
      checkOutput("t2_done", 32'(state), 32'(S_DONE));

      // Scoring: build combo 4, then a double hit, then a hit alongside a miss
      clearChart();
      romTime[0] = 12'd4000;
      resetDut();
      applyStimulus(8'h2C, '0, '0, '0);
      for (int i = 0; i < 4; i++) applyStimulus(8'h00, '0, 6'b000001, '0);
      checkOutput("t3_combo4", 32'(combo), 32'd4);
      applyStimulus(8'h00, '0, 6'b000011, '0);
      checkOutput("t3_double_score", 32'(score), 32'd60);
      checkOutput("t3_double_combo", 32'(combo), 32'd6);
      applyStimulus(8'h00, '0, 6'b000001, 6'b000100);
      checkOutput("t3_mixed_score", 32'(score), 32'd70);
      checkOutput("t3_mixed_combo", 32'(combo), 32'd0);

      // Saturation of score and combo under continuous full hits
      guard = 0;
      while (modelScore < 65535 && guard < 3000) begin
         applyStimulus(8'h00, '0, 6'b111111, '0);
         guard++;
      end
      applyStimulus(8'h00, '0, 6'b000001, '0);
      checkOutput("t4_score_sat", 32'(score), 32'hFFFF);
      checkOutput("t4_combo_sat", 32'(combo), 32'd255);

      // Abort while an entry is due on a free lane: no launch, straight to DONE
      romTime[0] = 12'd0;
      launchCount = 0;
      applyStimulus(8'h01, '0, '0, '0);
      checkOutput("t5_abort_launch", 32'(launchCount), 32'd0);
      checkOutput("t5_abort_state", 32'(state), 32'(S_DONE));
      applyStimulus(8'h00, '0, 6'b000001, '0);
      checkOutput("t5_done_hold_score", 32'(score), 32'hFFFF);

      // Reset pulled low mid-game at frame 50 with a stalled entry ready to go
      clearChart();
      romTime[0] = 12'd30;
      romLane[0] = 3'd0;
      romLast[0] = 1'b0;
      resetDut();
      applyStimulus(8'h2C, '0, '0, '0);
      guard = 0;
      while (modelFrame < 50 && guard < 100) begin
         applyStimulus(8'h00, 6'b000001, 6'($urandom) & 6'($urandom), '0);
         guard++;
      end
      checkOutput("t6_reached_frame50", 32'(modelFrame), 32'd50);
      #2;
      Reset = 1'b0;
      #1;
      modelReset();
      checkOutput("t6_rst_state", 32'(state), 32'(S_IDLE));
      checkOutput("t6_rst_addr", 32'(chart_addr), 32'd0);
      checkOutput("t6_rst_score", 32'(score), 32'd0);
      checkOutput("t6_rst_combo", 32'(combo), 32'd0);
      checkOutput("t6_rst_launch", 32'(launch), 32'd0);
      lane_busy = '0;
      @(posedge frame_clk);
      #1;
      checkOutput("t6_held_launch", 32'(launch), 32'd0);
      Reset = 1'b1;
      launchCount = 0;
      for (int i = 0; i < 3; i++) applyStimulus(8'h00, '0, '0, '0);
      checkOutput("t6_post_release_launch", 32'(launchCount), 32'd0);

      // Randomized games against the model, with and without last markers
      for (int r = 0; r < 4; r++) begin
         loadRandomChart(r[0]);
         resetDut();
         for (int c = 0; c < 1500; c++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 4) key = 8'h2C;
            else if (pick < 5) key = 8'h01;
            else if (pick < 8) key = 8'($urandom);
            else key = 8'h00;
            applyStimulus(key,
                          6'($urandom) & 6'($urandom),
                          6'($urandom) & 6'($urandom),
                          6'($urandom) & 6'($urandom) & 6'($urandom) & 6'($urandom));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
